// File: rtl/axil_reg_slave_pkg.sv
// Response codes and address constants shared by the AXI4-Lite control-register slave.
package axil_reg_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // Registers are 32-bit word aligned; the low byte-address bits are ignored.
  localparam int unsigned ADDR_LSB = 2;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite channel bundle (S00_AXI) between the master and the control-register slave.
interface axil_reg_slave_if
  import axil_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;

  axil_resp_t              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  axil_resp_t              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers plus per-register write pulses
// to the audio datapath; AW and W are buffered independently, one write outstanding.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axil_reg_slave_if.slave                S_AXI,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int IDX_W  = ADDR_WIDTH - int'(ADDR_LSB);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  r_aw_full, r_w_full, r_bvalid, r_rvalid;
  logic                  r_awready, r_wready, r_arready;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  axil_resp_t            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic                  w_wr_in_range, w_rd_in_range;
  logic                  w_aw_full_n, w_w_full_n, w_bvalid_n, w_rvalid_n;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  assign w_ar_idx      = S_AXI.ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_aw_hs       = S_AXI.AWVALID && r_awready;
  assign w_w_hs        = S_AXI.WVALID  && r_wready;
  assign w_ar_hs       = S_AXI.ARVALID && r_arready;
  assign w_commit      = r_aw_full && r_w_full && !r_bvalid;
  assign w_wr_in_range = 32'(r_aw_idx) < 32'(NUM_REGS);
  assign w_rd_in_range = 32'(w_ar_idx) < 32'(NUM_REGS);

  assign w_unused = ^{S_AXI.AWPROT, S_AXI.ARPROT,
                      S_AXI.AWADDR[ADDR_LSB-1:0], S_AXI.ARADDR[ADDR_LSB-1:0]};

  always_comb begin
    w_aw_full_n = r_aw_full;
    w_w_full_n  = r_w_full;
    w_bvalid_n  = r_bvalid;
    w_rvalid_n  = r_rvalid;
    if (w_commit) begin
      w_aw_full_n = 1'b0;
      w_w_full_n  = 1'b0;
      w_bvalid_n  = 1'b1;
    end else begin
      if (w_aw_hs) w_aw_full_n = 1'b1;
      if (w_w_hs)  w_w_full_n  = 1'b1;
      if (r_bvalid && S_AXI.BREADY) w_bvalid_n = 1'b0;
    end
    if (w_ar_hs) w_rvalid_n = 1'b1;
    else if (r_rvalid && S_AXI.RREADY) w_rvalid_n = 1'b0;
  end

  always_comb begin
    w_rd_data = '0;
    reg_out   = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (32'(w_ar_idx) == k) w_rd_data = r_regs[k];
      reg_out[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end
  end

  // READY outputs are registered from the next-state flags so no input reaches them combinationally.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_aw_full <= w_aw_full_n;
      r_w_full  <= w_w_full_n;
      r_bvalid  <= w_bvalid_n;
      r_rvalid  <= w_rvalid_n;
      r_awready <= !w_aw_full_n && !w_bvalid_n;
      r_wready  <= !w_w_full_n && !w_bvalid_n;
      r_arready <= !w_rvalid_n;
      if (w_aw_hs) r_aw_idx <= S_AXI.AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      if (w_w_hs) begin
        r_wdata <= S_AXI.WDATA;
        r_wstrb <= S_AXI.WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_rdata <= w_rd_in_range ? w_rd_data : '0;
        r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (w_commit && w_wr_in_range && (32'(r_aw_idx) == k)) begin
          r_wr_pulse[k] <= 1'b1;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (r_wstrb[b]) r_regs[k][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign S_AXI.AWREADY = r_awready;
  assign S_AXI.WREADY  = r_wready;
  assign S_AXI.BVALID  = r_bvalid;
  assign S_AXI.BRESP   = r_bresp;
  assign S_AXI.ARREADY = r_arready;
  assign S_AXI.RVALID  = r_rvalid;
  assign S_AXI.RRESP   = r_rresp;
  assign S_AXI.RDATA   = r_rdata;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
AXI4-Lite responder that gives the custom audio IP a bank of NUM_REGS read/write 32-bit control registers.
It is the slave end of the S00_AXI interface that the master VIP drives in the IP-level bench.
It accepts write address and write data independently and in either order, applies byte strobes, and returns read data with a registered response.
It exports the register contents and one-cycle write pulses to the audio datapath.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 is supported.
ADDR_WIDTH, 4, byte-address width on AWADDR/ARADDR.
NUM_REGS, 4, number of registers; must satisfy NUM_REGS*4 <= 2**ADDR_WIDTH.

Ports:
ACLK  in  1  single clock, all logic on its rising edge.
ARESETN  in  1  asynchronous, active-low reset.
S_AXI_AWADDR  in  ADDR_WIDTH  write byte address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
S_AXI_WDATA  in  DATA_WIDTH  write data.
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
S_AXI_RDATA  out  DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register k occupies bits [32k+31:32k].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register k is written.

Behaviour:
- Reset: one clock (ACLK); reset is asynchronous and active-low (ARESETN).
- Reset values: all registers 0; AWREADY, WREADY, ARREADY, BVALID and RVALID 0; BRESP, RRESP and RDATA 0; reg_wr_pulse 0.
- After reset release, the ready signals go high on the first rising edge of ACLK.
- Write path, AW and W are held in separate one-entry holding registers (aw_full, w_full):
  - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
  - AW and W may complete in the same cycle or in either order, any number of cycles apart.
- Write commit happens on the cycle when aw_full && w_full && !BVALID:
  - index = AWADDR[ADDR_WIDTH-1:2], AWADDR[1:0] ignored.
  - If index < NUM_REGS: each byte i with WSTRB[i]=1 is updated; BRESP=OKAY (2'b00); reg_wr_pulse[index]=1 on the next cycle.
  - Otherwise: no register change, no pulse, BRESP=SLVERR (2'b10).
  - Both holding registers clear; BVALID=1 on the next cycle.
- BVALID, BRESP and RVALID, RRESP, RDATA stay stable until their respective BREADY or RREADY handshake.
- Only one write is outstanding at a time; new AW and W are stalled until the B handshake.
- Write latency: minimum 2 cycles from the AW/W handshake to BVALID.
- Read path:
  - ARREADY = !RVALID.
  - On the AR handshake, RDATA, RRESP and RVALID are registered with 1-cycle latency.
  - Index in range: RDATA = reg[index], RRESP=OKAY.
  - Index out of range: RDATA=0, RRESP=SLVERR.
- Read and write to the same register in the same cycle: the read returns the pre-write value, because the commit updates at the end of that cycle.
- Read and write paths are fully independent; either may stall without blocking the other.
- ARESETN asserted mid-transaction: everything returns to reset values immediately; a partially accepted write is discarded.
- No FSM beyond the aw_full, w_full, BVALID and RVALID flags; no combinational path from any input to any READY output.

Decomposition:
- Package axil_reg_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, localparam ADDR_LSB=2, typedef axil_resp_t (logic [1:0]).
- Single module; no sub-module needed.
- The register bank with byte-strobe update stays inline.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back the same addresses -> BRESP=0 and RRESP=0 throughout, read data 0x1..0x4, reg_wr_pulse 0x1, 0x2, 0x4, 0x8 in turn.
- Write 0xAABBCCDD to 0x4 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5 -> read 0x4 returns 0xAA22CC44.
- W presented 5 cycles before AW (write 0x8, data 0x55) -> WREADY high, then BVALID 2 cycles after AW accept, reg 2 = 0x55.
- Write then read address 0x10 with NUM_REGS=4 and ADDR_WIDTH=5 -> BRESP=2'b10, registers unchanged, RDATA=0, RRESP=2'b10.
- Hold BREADY low for 10 cycles after a write -> BVALID and BRESP stable; AWREADY and WREADY low until the handshake; a read issued meanwhile completes normally.
- Drop ARESETN for 3 cycles while AW is held and W is pending -> all outputs 0; after release, reading 0x0 returns 0 and no write took effect.
